// File: rtl/vx_writeback_arb_pkg.sv
// Shared writeback types: warp/register index widths and the payload carried from commit to GPR.
// Used by the writeback arbiter, the GPR stage and the commit units.
package vx_writeback_arb_pkg;

    localparam int NUM_WARPS   = 4;
    localparam int NUM_REGS    = 32;
    localparam int NUM_THREADS = 4;
    localparam int NW_BITS     = $clog2(NUM_WARPS);
    localparam int NR_BITS     = $clog2(NUM_REGS);

    typedef struct packed {
        logic [NW_BITS-1:0]          wid;
        logic [31:0]                 PC;
        logic [NUM_THREADS-1:0]      tmask;
        logic [NR_BITS-1:0]          rd;
        logic [NUM_THREADS-1:0][31:0] data;
    } wb_payload_t;

endpackage

// File: rtl/vx_writeback_arb_rr_arbiter.sv
// Round-robin arbiter: picks the first request at or after the internal pointer.
// Latency: combinational grant; pointer advances past the winner on an enabled grant.
// Backpressure: enable low suppresses the grant and freezes the pointer.
module vx_writeback_arb_rr_arbiter #(
    parameter int NUM_REQS = 5
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQS-1:0]         requests,
    input  logic                        enable,
    output logic [NUM_REQS-1:0]         grant_onehot,
    output logic [$clog2(NUM_REQS)-1:0] grant_index,
    output logic                        grant_valid
);
    localparam int IDX_W = $clog2(NUM_REQS);

    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] idx;
    logic [IDX_W:0]   probe;
    logic             found;

    // Scan offsets from the far end so the smallest offset from ptr wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        probe = '0;
        for (int k = NUM_REQS - 1; k >= 0; k--) begin
            probe = {1'b0, ptr} + (IDX_W+1)'(k);
            if (probe >= (IDX_W+1)'(NUM_REQS)) begin
                probe = probe - (IDX_W+1)'(NUM_REQS);
            end
            if (requests[probe[IDX_W-1:0]]) begin
                found = 1'b1;
                idx   = probe[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        grant_onehot = '0;
        if (enable && found) begin
            grant_onehot[idx] = 1'b1;
        end
    end

    assign grant_index = idx;
    assign grant_valid = enable && found;

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (enable && found) begin
            ptr <= (idx == IDX_W'(NUM_REQS - 1)) ? '0 : idx + IDX_W'(1);
        end
    end

endmodule

// File: rtl/vx_writeback_arb.sv
// Commit-to-writeback arbiter: drains no-result commits, round-robins register writers onto one wb port.
// Latency: 1 cycle (registered output), one writeback per cycle sustained.
// Backpressure: wb_ready low holds the output entry and withholds ready from every writing source.
module vx_writeback_arb
    import vx_writeback_arb_pkg::*;
#(
    parameter int CORE_ID  = 0,
    parameter int NUM_REQS = 5
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic [NUM_REQS-1:0]                          commit_valid,
    output logic [NUM_REQS-1:0]                          commit_ready,
    input  logic [NUM_REQS-1:0]                          commit_wb,
    input  logic [NUM_REQS-1:0][NW_BITS-1:0]             commit_wid,
    input  logic [NUM_REQS-1:0][31:0]                    commit_PC,
    input  logic [NUM_REQS-1:0][NUM_THREADS-1:0]         commit_tmask,
    input  logic [NUM_REQS-1:0][NR_BITS-1:0]             commit_rd,
    input  logic [NUM_REQS-1:0][NUM_THREADS-1:0][31:0]   commit_data,
    output logic                                         wb_valid,
    input  logic                                         wb_ready,
    output logic [NW_BITS-1:0]                           wb_wid,
    output logic [31:0]                                  wb_PC,
    output logic [NUM_THREADS-1:0]                       wb_tmask,
    output logic [NR_BITS-1:0]                           wb_rd,
    output logic [NUM_THREADS-1:0][31:0]                 wb_data
);
    if (NUM_REQS < 2) begin : g_bad_num_reqs
        $error("NUM_REQS must be at least 2");
    end
    if (CORE_ID < 0) begin : g_bad_core_id
        $error("CORE_ID must be non-negative");
    end

    logic [NUM_REQS-1:0]         drain;
    logic [NUM_REQS-1:0]         req;
    logic [NUM_REQS-1:0]         grant_onehot;
    logic [$clog2(NUM_REQS)-1:0] grant_index;
    logic                        grant_valid;
    logic                        load;
    logic                        wb_valid_q;
    wb_payload_t                 wb_q;
    wb_payload_t                 sel;

    assign drain = commit_valid & ~commit_wb;
    assign req   = commit_valid & commit_wb;
    assign load  = !wb_valid_q || wb_ready;

    // Reset blocks the grant so no source believes it was consumed while the output is being cleared.
    vx_writeback_arb_rr_arbiter #(
        .NUM_REQS (NUM_REQS)
    ) u_rr_arbiter (
        .clk          (clk),
        .reset        (reset),
        .requests     (req),
        .enable       (load && !reset),
        .grant_onehot (grant_onehot),
        .grant_index  (grant_index),
        .grant_valid  (grant_valid)
    );

    assign commit_ready = drain | grant_onehot;

    always_comb begin
        sel       = '0;
        sel.wid   = commit_wid[grant_index];
        sel.PC    = commit_PC[grant_index];
        sel.tmask = commit_tmask[grant_index];
        sel.rd    = commit_rd[grant_index];
        sel.data  = commit_data[grant_index];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wb_valid_q <= 1'b0;
            wb_q       <= '0;
        end else if (load) begin
            wb_valid_q <= grant_valid;
            if (grant_valid) begin
                wb_q <= sel;
            end
        end
    end

    assign wb_valid = wb_valid_q;
    assign wb_wid   = wb_q.wid;
    assign wb_PC    = wb_q.PC;
    assign wb_tmask = wb_q.tmask;
    assign wb_rd    = wb_q.rd;
    assign wb_data  = wb_q.data;

endmodule

// File: tb/tb_vx_writeback_arb.sv
// Bench for vx_writeback_arb: per-source stimulus queues, a reference arbiter model and a payload scoreboard.
module tb_vx_writeback_arb;
    import vx_writeback_arb_pkg::*;

    localparam int N = 5;
    localparam logic [31:0] DRAIN_PC = 32'hDEAD_0002;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0]                        commit_valid = '0;
    logic [N-1:0]                        commit_ready;
    logic [N-1:0]                        commit_wb = '0;
    logic [N-1:0][NW_BITS-1:0]           commit_wid = '0;
    logic [N-1:0][31:0]                  commit_PC = '0;
    logic [N-1:0][NUM_THREADS-1:0]       commit_tmask = '0;
    logic [N-1:0][NR_BITS-1:0]           commit_rd = '0;
    logic [N-1:0][NUM_THREADS-1:0][31:0] commit_data = '0;
    logic                                wb_valid;
    logic                                wb_ready = 1'b1;
    logic [NW_BITS-1:0]                  wb_wid;
    logic [31:0]                         wb_PC;
    logic [NUM_THREADS-1:0]              wb_tmask;
    logic [NR_BITS-1:0]                  wb_rd;
    logic [NUM_THREADS-1:0][31:0]        wb_data;

    vx_writeback_arb #(.CORE_ID(0), .NUM_REQS(N)) dut (
        .clk          (clk),
        .reset        (reset),
        .commit_valid (commit_valid),
        .commit_ready (commit_ready),
        .commit_wb    (commit_wb),
        .commit_wid   (commit_wid),
        .commit_PC    (commit_PC),
        .commit_tmask (commit_tmask),
        .commit_rd    (commit_rd),
        .commit_data  (commit_data),
        .wb_valid     (wb_valid),
        .wb_ready     (wb_ready),
        .wb_wid       (wb_wid),
        .wb_PC        (wb_PC),
        .wb_tmask     (wb_tmask),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data)
    );

    typedef struct packed {
        logic        wb;
        wb_payload_t p;
    } item_t;

    item_t       srcq[N][$];
    wb_payload_t exp_q[$];
    int          gseq[$];
    int          gcyc[$];
    int          n_checks = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          n_xfer = 0;
    int          n_wb_pushed = 0;
    bit          saw_drain_pc = 1'b0;
    logic [N-1:0] fired = '0;

    // Reference model state
    logic        m_valid = 1'b0;
    int          m_ptr = 0;
    int          m_g;
    logic        m_load;
    logic [N-1:0] m_drn, m_req, m_rdy;
    wb_payload_t m_pl;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int s, input logic wb, input logic [NW_BITS-1:0] wid,
                        input logic [31:0] pc, input logic [NUM_THREADS-1:0] tm,
                        input logic [NR_BITS-1:0] rd, input logic [NUM_THREADS-1:0][31:0] d);
        item_t it;
        it.wb      = wb;
        it.p.wid   = wid;
        it.p.PC    = pc;
        it.p.tmask = tm;
        it.p.rd    = rd;
        it.p.data  = d;
        srcq[s].push_back(it);
        if (wb) n_wb_pushed++;
    endtask

    // Source driver: retire handshaken items, present queue fronts.
    initial forever begin
        @(posedge clk);
        cyc++;
        #2;
        for (int i = 0; i < N; i++) begin
            if (fired[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
            if (srcq[i].size() > 0) begin
                commit_valid[i] = 1'b1;
                commit_wb[i]    = srcq[i][0].wb;
                commit_wid[i]   = srcq[i][0].p.wid;
                commit_PC[i]    = srcq[i][0].p.PC;
                commit_tmask[i] = srcq[i][0].p.tmask;
                commit_rd[i]    = srcq[i][0].p.rd;
                commit_data[i]  = srcq[i][0].p.data;
            end else begin
                commit_valid[i] = 1'b0;
                commit_wb[i]    = 1'b0;
                commit_wid[i]   = '0;
                commit_PC[i]    = '0;
                commit_tmask[i] = '0;
                commit_rd[i]    = '0;
                commit_data[i]  = '0;
            end
        end
        fired = '0;
    end

    // Monitor and reference model, evaluated mid-cycle.
    initial forever begin
        @(negedge clk);
        m_drn  = commit_valid & ~commit_wb;
        m_req  = commit_valid & commit_wb;
        m_load = !m_valid || wb_ready;
        m_g    = -1;
        for (int k = 0; k < N; k++) begin
            if (m_g < 0 && m_req[(m_ptr + k) % N]) m_g = (m_ptr + k) % N;
        end
        m_rdy = m_drn;
        if (!reset && m_load && m_g >= 0) m_rdy[m_g] = 1'b1;

        chk("commit_ready", 256'(commit_ready), 256'(m_rdy));
        chk("wb_valid", 256'(wb_valid), 256'(m_valid));
        if (m_valid) begin
            if (exp_q.size() > 0)
                chk("wb_payload", 256'({wb_wid, wb_PC, wb_tmask, wb_rd, wb_data}), 256'(exp_q[0]));
            else
                chk("wb_payload_queue", 256'(0), 256'(1));
        end
        if (wb_valid && wb_PC == DRAIN_PC) saw_drain_pc = 1'b1;
        if (wb_valid && wb_ready) n_xfer++;
        for (int k = 0; k < N; k++) begin
            if (m_req[k] && commit_ready[k]) begin
                gseq.push_back(k);
                gcyc.push_back(cyc);
            end
        end
        fired = commit_valid & m_rdy;

        if (reset) begin
            m_valid = 1'b0;
            m_ptr   = 0;
            exp_q.delete();
        end else if (m_load) begin
            if (m_valid && exp_q.size() > 0) void'(exp_q.pop_front());
            if (m_g >= 0) begin
                m_pl.wid   = commit_wid[m_g];
                m_pl.PC    = commit_PC[m_g];
                m_pl.tmask = commit_tmask[m_g];
                m_pl.rd    = commit_rd[m_g];
                m_pl.data  = commit_data[m_g];
                exp_q.push_back(m_pl);
                m_valid = 1'b1;
                m_ptr   = (m_g + 1) % N;
            end else begin
                m_valid = 1'b0;
            end
        end
    end

    initial begin
        int total;
        // Reset state
        step(3);
        chk("rst_wb_valid", 256'(wb_valid), 256'(0));
        chk("rst_wb_PC", 256'(wb_PC), 256'(0));
        chk("rst_wb_data", 256'(wb_data), 256'(0));
        chk("rst_commit_ready", 256'(commit_ready), 256'(0));
        reset = 1'b0;
        step(1);

        // Single source
        gseq.delete();
        push(0, 1'b1, 2'd2, 32'h0000_0100, 4'b1011, 5'd5, {32'd4, 32'd3, 32'd2, 32'd1});
        step(4);
        chk("single_n", 256'(gseq.size()), 256'(1));
        if (gseq.size() > 0) chk("single_src", 256'(gseq[0]), 256'(0));

        // Fairness, pointer starts at 1 after the single grant
        gseq.delete();
        gcyc.delete();
        for (int r = 0; r < 3; r++)
            for (int s = 0; s < N; s++)
                push(s, 1'b1, NW_BITS'(s), 32'h1000 + 32'(r * 16 + s), 4'hF, NR_BITS'(r + s + 1),
                     {32'(r), 32'(s), 32'hA5A5_0000 + 32'(s), 32'h5A5A_0000 + 32'(r)});
        step(25);
        chk("fair_n", 256'(gseq.size()), 256'(15));
        for (int i = 0; i < gseq.size() && i < 15; i++)
            chk("fair_order", 256'(gseq[i]), 256'((i + 1) % N));
        if (gcyc.size() == 15) chk("fair_gapless", 256'(gcyc[14] - gcyc[0]), 256'(14));

        // Backpressure with pending sources 1 and 3, drain on source 2
        wb_ready = 1'b0;
        gseq.delete();
        gcyc.delete();
        push(0, 1'b1, 2'd0, 32'h0000_0200, 4'b0110, 5'd9, {32'h11, 32'h22, 32'h33, 32'h44});
        step(3);
        push(1, 1'b1, 2'd1, 32'h0000_0201, 4'b1111, 5'd10, {32'h55, 32'h66, 32'h77, 32'h88});
        push(3, 1'b1, 2'd3, 32'h0000_0203, 4'b1001, 5'd11, {32'h99, 32'hAA, 32'hBB, 32'hCC});
        push(2, 1'b0, 2'd2, DRAIN_PC, 4'b1111, 5'd12, {32'h1, 32'h1, 32'h1, 32'h1});
        step(4);
        chk("bp_hold_grants", 256'(gseq.size()), 256'(1));
        chk("bp_drained", 256'(srcq[2].size()), 256'(0));
        wb_ready = 1'b1;
        step(4);
        chk("bp_n", 256'(gseq.size()), 256'(3));
        if (gseq.size() == 3) begin
            chk("bp_first", 256'(gseq[1]), 256'(1));
            chk("bp_second", 256'(gseq[2]), 256'(3));
            chk("bp_b2b", 256'(gcyc[2] - gcyc[1]), 256'(1));
        end

        // rd=0 and tmask=0 pass-through
        push(1, 1'b1, 2'd1, 32'h0000_0300, 4'b0101, 5'd0, {32'h7, 32'h6, 32'h5, 32'h4});
        push(4, 1'b1, 2'd3, 32'h0000_0304, 4'b0000, 5'd7, {32'h3, 32'h2, 32'h1, 32'h0});
        step(5);

        // Reset mid-stream with a held entry and a pending source
        wb_ready = 1'b0;
        gseq.delete();
        push(2, 1'b1, 2'd2, 32'h0000_0402, 4'b1100, 5'd13, {32'hE, 32'hE, 32'hE, 32'hE});
        step(3);
        push(3, 1'b1, 2'd3, 32'h0000_0403, 4'b0011, 5'd14, {32'hF, 32'hF, 32'hF, 32'hF});
        step(2);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        wb_ready = 1'b1;
        chk("rst_mid_valid", 256'(wb_valid), 256'(0));
        push(0, 1'b1, 2'd0, 32'h0000_0400, 4'b1010, 5'd15, {32'hD, 32'hD, 32'hD, 32'hD});
        step(5);
        chk("rst_mid_n", 256'(gseq.size()), 256'(3));
        if (gseq.size() == 3) begin
            chk("rst_mid_first", 256'(gseq[1]), 256'(0));
            chk("rst_mid_second", 256'(gseq[2]), 256'(3));
        end

        step(3);
        total = 0;
        for (int s = 0; s < N; s++) total += srcq[s].size();
        chk("sources_empty", 256'(total), 256'(0));
        chk("xfer_count", 256'(n_xfer), 256'(n_wb_pushed - 1));
        chk("drain_leak", 256'(saw_drain_pc), 256'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
